// File: rtl/spi_bus_arbiter_if.sv
// rtl/spi_bus_arbiter_if.sv - requester, status and SPI master signals of the SPI bus arbiter
interface spi_bus_arbiter_if;
    logic        req0;
    logic [15:0] cmd0;
    logic        req1;
    logic [15:0] cmd1;
    logic        done0;
    logic        done1;
    logic        err;
    logic        owner;
    logic [15:0] rd_data;
    logic        busy;
    logic        mstr_wrt;
    logic [15:0] mstr_cmd;
    logic        mstr_done;
    logic [15:0] mstr_rd;
    logic        mstr_ss_n;
    logic        ss0_n;
    logic        ss1_n;

    modport slave (
        input  req0, cmd0, req1, cmd1, mstr_done, mstr_rd, mstr_ss_n,
        output done0, done1, err, owner, rd_data, busy, mstr_wrt, mstr_cmd, ss0_n, ss1_n
    );

    modport master (
        output req0, cmd0, req1, cmd1, mstr_done, mstr_rd, mstr_ss_n,
        input  done0, done1, err, owner, rd_data, busy, mstr_wrt, mstr_cmd, ss0_n, ss1_n
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - round-robin arbiter sharing one 16-bit SPI master between two requesters
module spi_bus_arbiter #(
    parameter int GAP_CYC = 2,
    parameter int TMO_CYC = 4096
) (
    input logic             clk,
    input logic             rst,
    spi_bus_arbiter_if.slave bus
);
    localparam int CW = $clog2(TMO_CYC);
    localparam logic [CW-1:0] TMO_LAST = CW'(TMO_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, GAP} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          owner_q, owner_d;
    logic          rr, rr_d;
    logic [15:0]   cmd_q, cmd_d;
    logic [15:0]   rd_q, rd_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic          err_c;
    logic          win;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            owner_q <= 1'b0;
            rr      <= 1'b0;
            cmd_q   <= '0;
            rd_q    <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            owner_q <= owner_d;
            rr      <= rr_d;
            cmd_q   <= cmd_d;
            rd_q    <= rd_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    // One shared counter: timeout while BUSY, gap length while in GAP.
    always_comb begin
        state_d = state;
        cnt_d   = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        owner_d = owner_q;
        rr_d    = rr;
        cmd_d   = cmd_q;
        rd_d    = rd_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err_c   = 1'b0;
        win     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 | bus.req1) begin
                    win     = (bus.req0 & bus.req1) ? rr : bus.req1;
                    owner_d = win;
                    cmd_d   = win ? bus.cmd1 : bus.cmd0;
                    rr_d    = ~win;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = BUSY;
            end
            BUSY: begin
                // A completion on the terminal count still wins over the timeout.
                if (bus.mstr_done) begin
                    rd_d    = bus.mstr_rd;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt == TMO_LAST) begin
                    err_c   = 1'b1;
                    cnt_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mstr_wrt = (state == LAUNCH);
    assign bus.busy     = (state != IDLE);
    assign bus.err      = err_c;
    assign bus.owner    = owner_q;
    assign bus.mstr_cmd = cmd_q;
    assign bus.rd_data  = rd_q;
    assign bus.done0    = done0_q;
    assign bus.done1    = done1_q;
    assign bus.ss0_n    = owner_q ? 1'b1 : bus.mstr_ss_n;
    assign bus.ss1_n    = owner_q ? bus.mstr_ss_n : 1'b1;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - directed self-checking bench for spi_bus_arbiter
module tb_spi_bus_arbiter;
    localparam int GAP = 2;
    localparam int TMO = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_bus_arbiter_if bus();

    spi_bus_arbiter #(.GAP_CYC(GAP), .TMO_CYC(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // SPI master model: replies model_lat cycles after mstr_wrt with cmd ^ 0ABC
    logic        model_en   = 1'b1;
    int          model_lat  = 3;
    logic        model_ss   = 1'b1;
    logic        model_done = 1'b0;
    logic [15:0] model_rd   = '0;
    logic [15:0] model_cmd  = '0;
    int          mcnt       = 0;

    assign bus.mstr_ss_n = model_ss | rst;
    assign bus.mstr_done = model_done & ~rst;
    assign bus.mstr_rd   = model_rd;

    initial forever begin
        @(posedge clk);
        #1;
        model_done = 1'b0;
        if (rst) begin
            mcnt     = 0;
            model_ss = 1'b1;
        end else if (bus.mstr_wrt) begin
            model_ss  = 1'b0;
            mcnt      = model_lat;
            model_cmd = bus.mstr_cmd;
        end else if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
                model_ss = 1'b1;
                if (model_en) begin
                    model_done = 1'b1;
                    model_rd   = model_cmd ^ 16'h0ABC;
                end
            end
        end
    end

    int n_done0 = 0, n_done1 = 0, n_err = 0, n_wrt = 0, cyc = 0;
    initial forever begin
        @(negedge clk);
        cyc = cyc + 1;
        if (bus.done0)    n_done0 = n_done0 + 1;
        if (bus.done1)    n_done1 = n_done1 + 1;
        if (bus.err)      n_err   = n_err + 1;
        if (bus.mstr_wrt) n_wrt   = n_wrt + 1;
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        model_en  = 1'b1;
        model_lat = 3;
        step;
        step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.cmd0 = 16'h0000;
        bus.cmd1 = 16'h0000;
        step;
        step;
        checks++;
        if ({bus.busy, bus.mstr_wrt, bus.done0, bus.done1, bus.err, bus.owner, bus.ss0_n, bus.ss1_n} !== 8'b0000_0011) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=%b", {bus.busy, bus.mstr_wrt, bus.done0, bus.done1, bus.err, bus.owner, bus.ss0_n, bus.ss1_n}, 8'b0000_0011);
        end
        checks++;
        if (bus.rd_data !== 16'h0000 || bus.mstr_cmd !== 16'h0000) begin
            failures++;
            $display("FAIL reset_data got rd=%h cmd=%h exp 0000/0000", bus.rd_data, bus.mstr_cmd);
        end
        rst = 1'b0;
        step;
    endtask

    task automatic test_single;
        int k;
        int d0;
        logic ss1_bad;
        do_reset;
        d0       = n_done0;
        bus.cmd0 = 16'h0000;
        bus.req0 = 1'b1;
        step;
        checks++;
        if (bus.mstr_wrt !== 1'b1 || bus.owner !== 1'b0 || bus.mstr_cmd !== 16'h0000) begin
            failures++;
            $display("FAIL single_launch got wrt=%b owner=%b cmd=%h exp 1/0/0000", bus.mstr_wrt, bus.owner, bus.mstr_cmd);
        end
        checks++;
        if (bus.ss0_n !== 1'b0) begin
            failures++;
            $display("FAIL single_ss0 got=%b exp=0", bus.ss0_n);
        end
        ss1_bad = 1'b0;
        k = 0;
        do begin
            step;
            k++;
            if (bus.ss1_n !== 1'b1) ss1_bad = 1'b1;
        end while (!bus.done0 && k < 20);
        bus.req0 = 1'b0;
        checks++;
        if (k !== 4) begin
            failures++;
            $display("FAIL single_done_latency got=%0d exp=4", k);
        end
        checks++;
        if (bus.rd_data !== 16'h0ABC) begin
            failures++;
            $display("FAIL single_rd_data got=%h exp=0abc", bus.rd_data);
        end
        repeat (10) begin
            step;
            if (bus.ss1_n !== 1'b1) ss1_bad = 1'b1;
        end
        checks++;
        if (ss1_bad !== 1'b0 || (n_done0 - d0) !== 1) begin
            failures++;
            $display("FAIL single_once got ss1_bad=%b done0_pulses=%0d exp 0/1", ss1_bad, n_done0 - d0);
        end
    endtask

    task automatic test_round_robin;
        int k;
        int last_wrt;
        logic [15:0] exp_cmd [2];
        logic [15:0] exp_rd  [2];
        exp_cmd[0] = 16'h1234; exp_cmd[1] = 16'hA500;
        exp_rd[0]  = 16'h1888; exp_rd[1]  = 16'hAFBC;
        rst       = 1'b1;
        model_en  = 1'b1;
        model_lat = 3;
        bus.cmd0  = 16'h1234;
        bus.cmd1  = 16'hA500;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        step;
        step;
        rst = 1'b0;
        last_wrt = 0;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (!bus.mstr_wrt && k < 20) begin
                step;
                k++;
            end
            checks++;
            if (bus.mstr_wrt !== 1'b1 || bus.owner !== 1'(i % 2) || bus.mstr_cmd !== exp_cmd[i % 2]) begin
                failures++;
                $display("FAIL rr_grant%0d got wrt=%b owner=%b cmd=%h exp 1/%0d/%h", i, bus.mstr_wrt, bus.owner, bus.mstr_cmd, i % 2, exp_cmd[i % 2]);
            end
            if (i > 0) begin
                checks++;
                if ((cyc - last_wrt) !== 7) begin
                    failures++;
                    $display("FAIL rr_spacing%0d got=%0d exp=7", i, cyc - last_wrt);
                end
            end
            last_wrt = cyc;
            k = 0;
            do begin
                step;
                k++;
            end while (!(bus.done0 | bus.done1) && k < 20);
            if (i == 3) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            checks++;
            if ({bus.done1, bus.done0} !== ((i % 2) ? 2'b10 : 2'b01) || bus.rd_data !== exp_rd[i % 2]) begin
                failures++;
                $display("FAIL rr_done%0d got done=%b rd=%h exp done=%b rd=%h", i, {bus.done1, bus.done0}, bus.rd_data, (i % 2) ? 2'b10 : 2'b01, exp_rd[i % 2]);
            end
        end
        repeat (6) step;
    endtask

    task automatic test_timeout;
        int k;
        int d0;
        int e0;
        do_reset;
        d0       = n_done0;
        e0       = n_err;
        model_en = 1'b0;
        bus.cmd0 = 16'h5555;
        bus.req0 = 1'b1;
        k = 0;
        while (!bus.mstr_wrt && k < 20) begin
            step;
            k++;
        end
        k = 0;
        do begin
            step;
            k++;
        end while (!bus.err && k < TMO + 20);
        bus.req0 = 1'b0;
        bus.cmd1 = 16'h00F0;
        bus.req1 = 1'b1;
        model_en = 1'b1;
        checks++;
        if (k !== TMO || bus.rd_data !== 16'h0000) begin
            failures++;
            $display("FAIL timeout_err got k=%0d rd=%h exp %0d/0000", k, bus.rd_data, TMO);
        end
        step;
        step;
        step;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_busy_drop got=%b exp=0", bus.busy);
        end
        k = 0;
        do begin
            step;
            k++;
        end while (!bus.done1 && k < 20);
        bus.req1 = 1'b0;
        checks++;
        if (bus.done1 !== 1'b1 || bus.owner !== 1'b1 || bus.rd_data !== 16'h0A4C) begin
            failures++;
            $display("FAIL timeout_next got done1=%b owner=%b rd=%h exp 1/1/0a4c", bus.done1, bus.owner, bus.rd_data);
        end
        repeat (4) step;
        checks++;
        if ((n_err - e0) !== 1 || (n_done0 - d0) !== 0) begin
            failures++;
            $display("FAIL timeout_counts got err=%0d done0=%0d exp 1/0", n_err - e0, n_done0 - d0);
        end
    endtask

    task automatic test_reset_busy;
        int k;
        int d0;
        int e0;
        do_reset;
        model_lat = 20;
        bus.cmd0  = 16'h7777;
        bus.req0  = 1'b1;
        k = 0;
        while (!bus.mstr_wrt && k < 20) begin
            step;
            k++;
        end
        step;
        step;
        step;
        d0  = n_done0;
        e0  = n_err;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.mstr_wrt, bus.done0, bus.done1, bus.err, bus.owner, bus.ss0_n, bus.ss1_n} !== 8'b0000_0011 || bus.mstr_cmd !== 16'h0000) begin
            failures++;
            $display("FAIL rstbusy_outputs got=%b cmd=%h exp=00000011/0000", {bus.busy, bus.mstr_wrt, bus.done0, bus.done1, bus.err, bus.owner, bus.ss0_n, bus.ss1_n}, bus.mstr_cmd);
        end
        bus.req0  = 1'b0;
        bus.cmd1  = 16'h3C3C;
        bus.req1  = 1'b1;
        model_lat = 3;
        step;
        step;
        rst = 1'b0;
        step;
        checks++;
        if (bus.mstr_wrt !== 1'b1 || bus.owner !== 1'b1) begin
            failures++;
            $display("FAIL rstbusy_grant got wrt=%b owner=%b exp 1/1", bus.mstr_wrt, bus.owner);
        end
        k = 0;
        do begin
            step;
            k++;
        end while (!bus.done1 && k < 20);
        bus.req1 = 1'b0;
        repeat (4) step;
        checks++;
        if (bus.rd_data !== 16'h3680 || (n_done0 - d0) !== 0 || (n_err - e0) !== 0) begin
            failures++;
            $display("FAIL rstbusy_after got rd=%h done0=%0d err=%0d exp 3680/0/0", bus.rd_data, n_done0 - d0, n_err - e0);
        end
    endtask

    task automatic test_drop;
        int k;
        int w0;
        int d1;
        do_reset;
        w0       = n_wrt;
        d1       = n_done1;
        bus.cmd1 = 16'h0F0F;
        bus.req1 = 1'b1;
        k = 0;
        while (!bus.mstr_wrt && k < 20) begin
            step;
            k++;
        end
        bus.req1 = 1'b0;
        repeat (20) step;
        checks++;
        if ((n_done1 - d1) !== 1 || (n_wrt - w0) !== 1 || bus.rd_data !== 16'h05B3) begin
            failures++;
            $display("FAIL drop_req got done1=%0d wrt=%0d rd=%h exp 1/1/05b3", n_done1 - d1, n_wrt - w0, bus.rd_data);
        end
    endtask

    task automatic test_coincident;
        int k;
        int e0;
        do_reset;
        e0        = n_err;
        model_lat = TMO;
        bus.cmd0  = 16'h0001;
        bus.req0  = 1'b1;
        k = 0;
        while (!bus.mstr_wrt && k < 20) begin
            step;
            k++;
        end
        k = 0;
        do begin
            step;
            k++;
        end while (!bus.done0 && k < TMO + 20);
        bus.req0 = 1'b0;
        checks++;
        if (k !== TMO + 1 || bus.rd_data !== 16'h0ABD) begin
            failures++;
            $display("FAIL coincident_done got k=%0d rd=%h exp %0d/0abd", k, bus.rd_data, TMO + 1);
        end
        repeat (4) step;
        checks++;
        if ((n_err - e0) !== 0) begin
            failures++;
            $display("FAIL coincident_err got=%0d exp=0", n_err - e0);
        end
    endtask

    initial begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.cmd0 = 16'h0000;
        bus.cmd1 = 16'h0000;
        test_reset;
        test_single;
        test_round_robin;
        test_timeout;
        test_reset_busy;
        test_drop;
        test_coincident;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
